riscv_i32_trace_buffer: RTL and testbench
=========================================

RISCV_I32_TRACE_BUFFER -- requirements
Module: riscv_i32_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 5, log2 of the number of trace entries (depth = 2^DEPTH_LOG2).
REQ-002 SHALL have one clock and one reset: clk (input, 1, free-running clock), clk__enable (input, 1, clock enable) and reset (input, 1, asynchronous, active-high).
REQ-003 SHALL have trace__instr_valid, trace__instr_pc, trace__instruction__data, trace__rfw_retire, trace__rfw_rd, trace__rfw_data, trace__branch_taken and trace__trap as inputs of width 1, 32, 32, 1, 5, 32, 1 and 1, forming the RISC-V trace bundle.
REQ-004 SHALL have riscv_clk_enable (input, 1), asserted if the RISC-V ticks on this edge.
REQ-005 SHALL have the control inputs arm (1, start capture pulse), abort (1, return to idle pulse), trigger_pc_en (1), trigger_pc (32), trigger_on_trap (1) and post_count (DEPTH_LOG2, entries captured after the trigger).
REQ-006 SHALL have the read inputs rd_ready (1) and the outputs rd_valid (1), rd_pc (32), rd_instr (32), rd_flags (2, {trap, branch_taken}), rd_rfw_rd (5) and rd_rfw_data (32).
REQ-007 SHALL have the status outputs state (2), count (DEPTH_LOG2+1, entries held) and overflow (1, at least one entry overwritten).

Function
REQ-008 SHALL treat every register update as qualified by clk__enable; with clk__enable low, all state holds.
REQ-009 SHALL define a capture as clk__enable & riscv_clk_enable & trace__instr_valid; an entry holds pc, instruction, branch_taken, trap, and the rfw fields when trace__rfw_retire is set (zero otherwise).
REQ-010 SHALL implement four states with encodings IDLE=0, ARMED=1, POST=2 and DONE=3.
REQ-011 IDLE: captures SHALL be ignored; arm -> ARMED, clearing wr_ptr, rd_ptr, count and overflow.
REQ-012 ARMED: each capture SHALL write at wr_ptr and then do wr_ptr++ modulo depth; count SHALL increment and saturate at depth; a capture at count==depth SHALL overwrite the oldest entry, advance rd_ptr and set overflow.
REQ-013 ARMED: the trigger SHALL be a capture with (trigger_pc_en & pc==trigger_pc) | (trigger_on_trap & trap); the triggering entry SHALL be stored, then -> POST with remaining=post_count, or -> DONE directly if post_count==0.
REQ-014 POST: each capture SHALL be stored per REQ-012 and decrement remaining; the capture that takes remaining 1->0 SHALL be stored and cause -> DONE.
REQ-015 DONE: no further captures SHALL be taken; rd_valid=(count!=0); rd_* SHALL be the entry at rd_ptr, combinationally, with zero latency.
REQ-016 A read SHALL complete when rd_valid & rd_ready, doing rd_ptr++ modulo depth and count--; after the last entry, rd_valid SHALL deassert and the state SHALL remain DONE.
REQ-017 arm in DONE SHALL restart per REQ-011; arm in ARMED or POST SHALL be ignored.
REQ-018 abort SHALL force IDLE from any state on the next enabled edge, dropping rd_valid; abort SHALL win over a simultaneous arm.
REQ-019 rd_valid SHALL be 0 outside DONE.
REQ-020 Storage SHALL be a register or RAM array with no reset; outputs in DONE SHALL never expose unwritten entries.

Reset
REQ-021 While reset is high: state=IDLE, wr_ptr=0, rd_ptr=0, count=0, overflow=0, rd_valid=0, remaining=0.
REQ-022 Reset asserted mid-capture or mid-readout SHALL discard all contents; the first post-reset cycle SHALL behave as IDLE.

Configuration
REQ-023 Macro RISCV_I32_TRACE_BUFFER_RFW_EN: when defined, the rfw fields SHALL be stored and presented per REQ-009.
REQ-024 Without RISCV_I32_TRACE_BUFFER_RFW_EN: no rfw storage; rd_rfw_rd and rd_rfw_data SHALL be tied to 0; the rfw inputs SHALL be unused; all other behaviour SHALL be unchanged.

Verification
REQ-025 Basic trigger: DEPTH_LOG2=3, arm, 5 captures with pc 0x100..0x110, trigger_pc=0x108, post_count=2 -> DONE after the 5th capture; count=5, overflow=0; reads pc 0x100,0x104,0x108,0x10C,0x110.
REQ-026 Wrap: depth 8, 12 captures pc 0x0..0x2C before a trap trigger (trigger_on_trap=1) with post_count=0 on the 13th (pc 0x30) -> count=8, overflow=1; reads pc 0x14..0x30.
REQ-027 Enables: captures with riscv_clk_enable=0, or with clk__enable=0, are not stored; count stays 0 after 4 such cycles.
REQ-028 Read backpressure: in DONE with count=3, rd_ready low for 5 cycles -> rd_pc stable and count=3; rd_ready high for 3 cycles -> count=0, rd_valid=0.
REQ-029 Abort vs arm: in POST, assert abort and arm together -> state=0 next cycle, rd_valid=0; a following arm -> state=1, count=0.
REQ-030 RFW: with RISCV_I32_TRACE_BUFFER_RFW_EN, a capture with rfw_retire=1, rd=5, data=0xDEADBEEF reads back those values; without the macro it reads back 0.

Source files
------------

// File: rtl/riscv_i32_trace_buffer_if.sv
// RISC-V retirement trace bundle plus the core's tick qualifier.
// The core drives through master; the trace buffer samples through slave.
interface riscv_i32_trace_buffer_if;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] instruction_data;
    logic        rfw_retire;
    logic [4:0]  rfw_rd;
    logic [31:0] rfw_data;
    logic        branch_taken;
    logic        trap;
    logic        riscv_clk_enable;

    modport master (
        output instr_valid, instr_pc, instruction_data, rfw_retire,
               rfw_rd, rfw_data, branch_taken, trap, riscv_clk_enable
    );

    modport slave (
        input  instr_valid, instr_pc, instruction_data, rfw_retire,
               rfw_rd, rfw_data, branch_taken, trap, riscv_clk_enable
    );
endinterface

// File: rtl/riscv_i32_trace_buffer.sv
// Circular trace capture of retired RISC-V instructions with PC/trap trigger and post-trigger window.
// Define RISCV_I32_TRACE_BUFFER_RFW_EN to also store the register-file write fields.
module riscv_i32_trace_buffer #(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  clk__enable,
    input  logic                  reset,
    riscv_i32_trace_buffer_if.slave trace,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trigger_pc_en,
    input  logic [31:0]           trigger_pc,
    input  logic                  trigger_on_trap,
    input  logic [DEPTH_LOG2-1:0] post_count,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [31:0]           rd_pc,
    output logic [31:0]           rd_instr,
    output logic [1:0]            rd_flags,
    output logic [4:0]            rd_rfw_rd,
    output logic [31:0]           rd_rfw_data,
    output logic [1:0]            state,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] remaining;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overflow_q;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [1:0]  flags_mem [DEPTH];
`ifdef RISCV_I32_TRACE_BUFFER_RFW_EN
    logic [4:0]  rfw_rd_mem   [DEPTH];
    logic [31:0] rfw_data_mem [DEPTH];
`endif

    logic capture;
    logic store;
    logic trig;
    logic full;
    logic rd_fire;

    assign capture = clk__enable & trace.riscv_clk_enable & trace.instr_valid;
    assign store   = capture & ~abort & ((state_q == ARMED) | (state_q == POST));
    assign trig    = (trigger_pc_en & (trace.instr_pc == trigger_pc)) | (trigger_on_trap & trace.trap);
    assign full    = (count_q == CNT_FULL);
    assign rd_valid = (state_q == DONE) && (count_q != '0);
    assign rd_fire  = rd_valid & rd_ready;

    // Storage carries no reset; count gates everything that reaches the outputs.
    always_ff @(posedge clk) begin
        if (store) begin
            pc_mem[wr_ptr]    <= trace.instr_pc;
            instr_mem[wr_ptr] <= trace.instruction_data;
            flags_mem[wr_ptr] <= {trace.trap, trace.branch_taken};
`ifdef RISCV_I32_TRACE_BUFFER_RFW_EN
            rfw_rd_mem[wr_ptr]   <= trace.rfw_retire ? trace.rfw_rd   : 5'd0;
            rfw_data_mem[wr_ptr] <= trace.rfw_retire ? trace.rfw_data : 32'd0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            remaining  <= '0;
        end else if (clk__enable) begin
            if (abort) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (arm) begin
                            state_q    <= ARMED;
                            wr_ptr     <= '0;
                            rd_ptr     <= '0;
                            count_q    <= '0;
                            overflow_q <= 1'b0;
                        end else if (rd_fire) begin
                            rd_ptr  <= rd_ptr + PTR_ONE;
                            count_q <= count_q - CNT_ONE;
                        end
                    end
                    ARMED, POST: begin
                        if (store) begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                            if (full) begin
                                rd_ptr     <= rd_ptr + PTR_ONE;
                                overflow_q <= 1'b1;
                            end else begin
                                count_q <= count_q + CNT_ONE;
                            end
                            if (state_q == ARMED) begin
                                if (trig) begin
                                    remaining <= post_count;
                                    state_q   <= (post_count == PTR_ZERO) ? DONE : POST;
                                end
                            end else begin
                                remaining <= remaining - PTR_ONE;
                                if (remaining == PTR_ONE)
                                    state_q <= DONE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign state    = state_q;
    assign count    = count_q;
    assign overflow = overflow_q;

    assign rd_pc    = rd_valid ? pc_mem[rd_ptr]    : 32'd0;
    assign rd_instr = rd_valid ? instr_mem[rd_ptr] : 32'd0;
    assign rd_flags = rd_valid ? flags_mem[rd_ptr] : 2'd0;
`ifdef RISCV_I32_TRACE_BUFFER_RFW_EN
    assign rd_rfw_rd   = rd_valid ? rfw_rd_mem[rd_ptr]   : 5'd0;
    assign rd_rfw_data = rd_valid ? rfw_data_mem[rd_ptr] : 32'd0;
`else
    assign rd_rfw_rd   = 5'd0;
    assign rd_rfw_data = 32'd0;
`endif
endmodule

// File: tb/tb_riscv_i32_trace_buffer.sv
// Directed bench for riscv_i32_trace_buffer at depth 8: trigger, wrap, enables,
// backpressure, abort priority, rfw fields and mid-run reset.
module tb_riscv_i32_trace_buffer;
    localparam int DL2 = 3;

    logic            clk = 1'b0;
    logic            clk__enable;
    logic            reset;
    logic            arm, abort, trigger_pc_en, trigger_on_trap, rd_ready;
    logic [31:0]     trigger_pc;
    logic [DL2-1:0]  post_count;
    logic            rd_valid;
    logic [31:0]     rd_pc, rd_instr, rd_rfw_data;
    logic [1:0]      rd_flags, state;
    logic [4:0]      rd_rfw_rd;
    logic [DL2:0]    count;
    logic            overflow;

    int checks = 0;
    int errors = 0;

    riscv_i32_trace_buffer_if tif ();

    riscv_i32_trace_buffer #(.DEPTH_LOG2(DL2)) dut (
        .clk             (clk),
        .clk__enable     (clk__enable),
        .reset           (reset),
        .trace           (tif.slave),
        .arm             (arm),
        .abort           (abort),
        .trigger_pc_en   (trigger_pc_en),
        .trigger_pc      (trigger_pc),
        .trigger_on_trap (trigger_on_trap),
        .post_count      (post_count),
        .rd_ready        (rd_ready),
        .rd_valid        (rd_valid),
        .rd_pc           (rd_pc),
        .rd_instr        (rd_instr),
        .rd_flags        (rd_flags),
        .rd_rfw_rd       (rd_rfw_rd),
        .rd_rfw_data     (rd_rfw_data),
        .state           (state),
        .count           (count),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic capture(input logic [31:0] pc, input logic trap, input logic br,
                           input logic retire, input logic [4:0] rd, input logic [31:0] data);
        tif.instr_pc         = pc;
        tif.instruction_data = pc ^ 32'hA5A5_0000;
        tif.trap             = trap;
        tif.branch_taken     = br;
        tif.rfw_retire       = retire;
        tif.rfw_rd           = rd;
        tif.rfw_data         = data;
        tif.instr_valid      = 1'b1;
        tick();
        tif.instr_valid      = 1'b0;
        tif.trap             = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (state !== 2'd0 || count !== 4'd0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: state=%0d count=%0d ovf=%0b rd_valid=%0b, want 0 0 0 0",
                     state, count, overflow, rd_valid);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        trigger_pc_en = 1'b1;
        trigger_pc    = 32'h108;
        post_count    = 3'd2;
        pulse_arm();
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL basic_arm: state=%0d want 1", state);
        end
        for (int i = 0; i < 5; i++) begin
            capture(32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            if (i == 2) begin
                checks++;
                if (state !== 2'd2) begin
                    errors++;
                    $display("FAIL basic_post: state=%0d want 2", state);
                end
            end
        end
        checks++;
        if (state !== 2'd3 || count !== 4'd5 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: state=%0d count=%0d ovf=%0b, want 3 5 0", state, count, overflow);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_pc !== 32'h100 + 32'(4 * i) ||
                rd_instr !== ((32'h100 + 32'(4 * i)) ^ 32'hA5A5_0000)) begin
                errors++;
                $display("FAIL basic_read%0d: valid=%0b pc=%h instr=%h, want 1 %h", i, rd_valid,
                         rd_pc, rd_instr, 32'h100 + 32'(4 * i));
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || count !== 4'd0 || state !== 2'd3) begin
            errors++;
            $display("FAIL basic_empty: valid=%0b count=%0d state=%0d, want 0 0 3", rd_valid, count, state);
        end
        trigger_pc_en = 1'b0;
    endtask

    task automatic test_wrap();
        trigger_on_trap = 1'b1;
        post_count      = 3'd0;
        pulse_arm();
        for (int i = 0; i < 12; i++)
            capture(32'(4 * i), 1'b0, i[0], 1'b0, 5'd0, 32'd0);
        capture(32'h30, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (state !== 2'd3 || count !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done: state=%0d count=%0d ovf=%0b, want 3 8 1", state, count, overflow);
        end
        rd_ready = 1'b1;
        for (int i = 5; i < 13; i++) begin
            logic [1:0] fl;
            fl = (i == 12) ? 2'b10 : {1'b0, i[0]};
            checks++;
            if (rd_pc !== 32'(4 * i) || rd_flags !== fl) begin
                errors++;
                $display("FAIL wrap_read%0d: pc=%h flags=%b, want %h %b", i, rd_pc, rd_flags, 32'(4 * i), fl);
            end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_enables();
        pulse_arm();
        tif.riscv_clk_enable = 1'b0;
        capture(32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        capture(32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tif.riscv_clk_enable = 1'b1;
        clk__enable = 1'b0;
        capture(32'h208, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        capture(32'h20C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        clk__enable = 1'b1;
        checks++;
        if (count !== 4'd0 || state !== 2'd1) begin
            errors++;
            $display("FAIL enables: count=%0d state=%0d, want 0 1", count, state);
        end
    endtask

    task automatic test_backpressure();
        capture(32'h300, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        capture(32'h304, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        capture(32'h308, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (state !== 2'd3 || count !== 4'd3 || rd_pc !== 32'h300) begin
            errors++;
            $display("FAIL bp_hold: state=%0d count=%0d pc=%h, want 3 3 00000300", state, count, rd_pc);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rd_ready = 1'b0;
        checks++;
        if (count !== 4'd0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: count=%0d valid=%0b, want 0 0", count, rd_valid);
        end
    endtask

    task automatic test_abort();
        post_count = 3'd3;
        pulse_arm();
        capture(32'h400, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL abort_post: state=%0d want 2", state);
        end
        abort = 1'b1;
        arm   = 1'b1;
        tick();
        abort = 1'b0;
        arm   = 1'b0;
        checks++;
        if (state !== 2'd0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_win: state=%0d valid=%0b, want 0 0", state, rd_valid);
        end
        pulse_arm();
        checks++;
        if (state !== 2'd1 || count !== 4'd0) begin
            errors++;
            $display("FAIL abort_rearm: state=%0d count=%0d, want 1 0", state, count);
        end
    endtask

    task automatic test_rfw();
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
`ifdef RISCV_I32_TRACE_BUFFER_RFW_EN
        exp_rd   = 5'd5;
        exp_data = 32'hDEAD_BEEF;
`else
        exp_rd   = 5'd0;
        exp_data = 32'd0;
`endif
        post_count = 3'd0;
        capture(32'h500, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        checks++;
        if (rd_valid !== 1'b1 || rd_rfw_rd !== exp_rd || rd_rfw_data !== exp_data || rd_flags !== 2'b11) begin
            errors++;
            $display("FAIL rfw: valid=%0b rd=%0d data=%h flags=%b, want 1 %0d %h 11",
                     rd_valid, rd_rfw_rd, rd_rfw_data, rd_flags, exp_rd, exp_data);
        end
    endtask

    task automatic test_reset_mid();
        pulse_arm();
        capture(32'h600, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        capture(32'h604, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        reset = 1'b1;
        #2;
        checks++;
        if (state !== 2'd0 || count !== 4'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: state=%0d count=%0d ovf=%0b, want 0 0 0", state, count, overflow);
        end
        tick();
        reset = 1'b0;
        capture(32'h608, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (state !== 2'd0 || count !== 4'd0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: state=%0d count=%0d valid=%0b, want 0 0 0", state, count, rd_valid);
        end
    endtask

    initial begin
        clk__enable          = 1'b1;
        reset                = 1'b1;
        arm                  = 1'b0;
        abort                = 1'b0;
        trigger_pc_en        = 1'b0;
        trigger_pc           = 32'd0;
        trigger_on_trap      = 1'b0;
        post_count           = '0;
        rd_ready             = 1'b0;
        tif.instr_valid      = 1'b0;
        tif.instr_pc         = 32'd0;
        tif.instruction_data = 32'd0;
        tif.rfw_retire       = 1'b0;
        tif.rfw_rd           = 5'd0;
        tif.rfw_data         = 32'd0;
        tif.branch_taken     = 1'b0;
        tif.trap             = 1'b0;
        tif.riscv_clk_enable = 1'b1;

        test_reset();
        test_basic();
        test_wrap();
        test_enables();
        test_backpressure();
        test_abort();
        test_rfw();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
